// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the single-port RAM arbiter.
// Used by the instruction-fetch, MEM-stage and program-loader ports.
package mem_arb_pkg;
  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, EXIT = 2'd2} arb_state_e;
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_IF = 2'd1, REQ_DM = 2'd2, REQ_LD = 2'd3} req_id_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side bus of the arbiter.
// master = requesters + RAM model, slave = arbiter.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic              dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              ld_mode, ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_mode, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_mode, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Counts consecutive denied fetch cycles; promote_o once the limit is reached.
module starve_counter #(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic promote_o
);
  localparam int CW = $clog2(STARVE_LIM + 2);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && cnt_q != LIM) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign promote_o = (cnt_q == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, MEM-stage and loader accesses onto one synchronous RAM port.
// Grants are combinational; read data returns one cycle later tagged by requester id.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                stall_o
);
  arb_state_e state_q, state_d;
  req_id_e    tag_q, tag_d, gnt_id;
  logic       if_gnt, dm_gnt, ld_gnt, promote, starve_clr;

  assign starve_clr = (state_q != RUN) | ~bus.if_req | if_gnt;

  starve_counter #(.STARVE_LIM(STARVE_LIM)) u_starve (
    .clk(clk), .rst_n(rst_n),
    .inc_i(~starve_clr), .clr_i(starve_clr),
    .promote_o(promote)
  );

  // Grants are forced low during reset so nothing reaches the RAM.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        RUN: if (!bus.ld_mode) begin
          dm_gnt = bus.dm_req & ~(promote & bus.if_req);
          if_gnt = bus.if_req & ~dm_gnt;
        end
        LOAD:    ld_gnt = bus.ld_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_id = REQ_NONE;
    if (if_gnt)      gnt_id = REQ_IF;
    else if (dm_gnt) gnt_id = REQ_DM;
    else if (ld_gnt) gnt_id = REQ_LD;
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (gnt_id)
      REQ_IF: bus.mem_addr = bus.if_addr;
      REQ_DM: begin
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
      end
      REQ_LD: begin
        bus.mem_we    = bus.ld_we;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_en = if_gnt | dm_gnt | ld_gnt;
  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;
  assign bus.ld_gnt = ld_gnt;

  assign tag_d = (gnt_id != REQ_NONE && !bus.mem_we) ? gnt_id : REQ_NONE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.ld_mode)  state_d = LOAD;
      LOAD:    if (!bus.ld_mode) state_d = EXIT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      tag_q   <= REQ_NONE;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end

  assign bus.if_rvalid = (tag_q == REQ_IF);
  assign bus.dm_rvalid = (tag_q == REQ_DM);
  assign bus.ld_rvalid = (tag_q == REQ_LD);
  assign bus.rdata     = (tag_q != REQ_NONE) ? bus.mem_rdata : '0;

  assign stall_o = rst_n & ((bus.if_req & ~if_gnt) | (bus.dm_req & ~dm_gnt));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, priority/starvation, writes,
// loader hand-over, EXIT cycle and reset discard of an in-flight read.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_o;
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.ld_req = 1'b0; bus.ld_we = 1'b0;
  endtask

  initial begin
    bus.if_req = 1'b1; bus.if_addr = 8'h33;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h44; bus.dm_wdata = 32'h11112222;
    bus.ld_mode = 1'b0; bus.ld_req = 1'b0; bus.ld_we = 1'b0;
    bus.ld_addr = 8'h00; bus.ld_wdata = 32'h0;
    bus.mem_rdata = 32'hFFFFFFFF;

    // Reset: outputs quiet even with requests present
    #2;
    chk1("rst_if_gnt", bus.if_gnt, 1'b0);
    chk1("rst_dm_gnt", bus.dm_gnt, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_stall", stall_o, 1'b0);
    chkw("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chkw("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chkw("rst_rdata", bus.rdata, 32'h0);
    chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
    idle_reqs();
    tick();
    rst_n = 1'b1;
    tick();

    // Single fetch read
    bus.if_req = 1'b1; bus.if_addr = 8'h05; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk1("f_if_gnt", bus.if_gnt, 1'b1);
    chk1("f_mem_en", bus.mem_en, 1'b1);
    chk1("f_mem_we", bus.mem_we, 1'b0);
    chkw("f_mem_addr", 32'(bus.mem_addr), 32'h05);
    chk1("f_stall", stall_o, 1'b0);
    tick();
    bus.if_req = 1'b0;
    chk1("f_if_rvalid", bus.if_rvalid, 1'b1);
    chk1("f_dm_rvalid", bus.dm_rvalid, 1'b0);
    chkw("f_rdata", bus.rdata, 32'hDEADBEEF);
    tick();
    chk1("f_rvalid_drop", bus.if_rvalid, 1'b0);

    // Contention: data wins 4 cycles, then the starved fetch is promoted
    bus.if_req = 1'b1; bus.if_addr = 8'h05;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h10;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk1($sformatf("c%0d_dm_gnt", c), bus.dm_gnt, (c != 4));
      chk1($sformatf("c%0d_if_gnt", c), bus.if_gnt, (c == 4));
      chk1($sformatf("c%0d_stall", c), stall_o, 1'b1);
      chkw($sformatf("c%0d_addr", c), 32'(bus.mem_addr), (c == 4) ? 32'h05 : 32'h10);
      tick();
      chk1($sformatf("c%0d_dm_rvalid", c), bus.dm_rvalid, (c != 4));
      chk1($sformatf("c%0d_if_rvalid", c), bus.if_rvalid, (c == 4));
    end
    idle_reqs();
    tick();

    // Data write: no read return
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h20; bus.dm_wdata = 32'h12345678;
    #1;
    chk1("w_dm_gnt", bus.dm_gnt, 1'b1);
    chk1("w_mem_en", bus.mem_en, 1'b1);
    chk1("w_mem_we", bus.mem_we, 1'b1);
    chkw("w_mem_addr", 32'(bus.mem_addr), 32'h20);
    chkw("w_mem_wdata", bus.mem_wdata, 32'h12345678);
    tick();
    idle_reqs();
    chk1("w_dm_rvalid", bus.dm_rvalid, 1'b0);
    chkw("w_rdata", bus.rdata, 32'h0);
    tick();

    // Fetch granted, then loader takes ownership; return still delivered
    bus.if_req = 1'b1; bus.if_addr = 8'h07; bus.mem_rdata = 32'hCAFEF00D;
    #1;
    chk1("h_if_gnt", bus.if_gnt, 1'b1);
    tick();
    bus.ld_mode = 1'b1;
    #1;
    chk1("h_if_rvalid", bus.if_rvalid, 1'b1);
    chkw("h_rdata", bus.rdata, 32'hCAFEF00D);
    chk1("h_no_if_gnt", bus.if_gnt, 1'b0);
    chk1("h_mem_en", bus.mem_en, 1'b0);
    chk1("h_stall", stall_o, 1'b1);
    tick();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 8'h3F; bus.ld_wdata = 32'hA5A5A5A5;
    #1;
    chk1("l_if_rvalid", bus.if_rvalid, 1'b0);
    chk1("l_ld_gnt", bus.ld_gnt, 1'b1);
    chk1("l_if_gnt", bus.if_gnt, 1'b0);
    chk1("l_stall", stall_o, 1'b1);
    chk1("l_mem_we", bus.mem_we, 1'b1);
    chkw("l_mem_addr", 32'(bus.mem_addr), 32'h3F);
    chkw("l_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    tick();
    bus.ld_we = 1'b0; bus.mem_rdata = 32'h0BADCAFE;
    #1;
    chk1("lr_ld_gnt", bus.ld_gnt, 1'b1);
    chk1("lr_mem_we", bus.mem_we, 1'b0);
    tick();
    bus.ld_req = 1'b0;
    chk1("lr_ld_rvalid", bus.ld_rvalid, 1'b1);
    chk1("lr_if_rvalid", bus.if_rvalid, 1'b0);
    chkw("lr_rdata", bus.rdata, 32'h0BADCAFE);

    // Release loader: LOAD(ld_mode=0) -> one EXIT cycle -> RUN
    bus.ld_mode = 1'b0;
    #1;
    chk1("x0_if_gnt", bus.if_gnt, 1'b0);
    chk1("x0_ld_gnt", bus.ld_gnt, 1'b0);
    tick();
    bus.ld_req = 1'b1;
    #1;
    chk1("x1_if_gnt", bus.if_gnt, 1'b0);
    chk1("x1_ld_gnt", bus.ld_gnt, 1'b0);
    chk1("x1_mem_en", bus.mem_en, 1'b0);
    chk1("x1_stall", stall_o, 1'b1);
    tick();
    #1;
    chk1("x2_if_gnt", bus.if_gnt, 1'b1);
    chk1("x2_ld_gnt", bus.ld_gnt, 1'b0);
    chk1("x2_stall", stall_o, 1'b0);
    tick();
    idle_reqs();
    chk1("x2_if_rvalid", bus.if_rvalid, 1'b1);
    tick();

    // Reset during data reads: pending return discarded
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h44; bus.mem_rdata = 32'h55AA55AA;
    #1;
    chk1("r_dm_gnt", bus.dm_gnt, 1'b1);
    tick();
    chk1("r_dm_rvalid", bus.dm_rvalid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("r_async_rvalid", bus.dm_rvalid, 1'b0);
    chk1("r_dm_gnt_rst", bus.dm_gnt, 1'b0);
    chk1("r_mem_en_rst", bus.mem_en, 1'b0);
    chk1("r_stall_rst", stall_o, 1'b0);
    chkw("r_addr_rst", 32'(bus.mem_addr), 32'h0);
    chkw("r_rdata_rst", bus.rdata, 32'h0);
    tick();
    chk1("r_rvalid_held", bus.dm_rvalid, 1'b0);
    idle_reqs();
    rst_n = 1'b1;
    tick();
    chk1("r_rvalid_after", bus.dm_rvalid, 1'b0);
    chkw("r_rdata_after", bus.rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
